// File: rtl/pipe_addsub_if.sv
// Operand/result handshake bundle for pipe_addsub.
// The producer/consumer side uses master; the adder uses slave.
interface pipe_addsub_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] q;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] r;
  logic             carry;
  logic             ovf;

  modport master (
    output in_valid, p, q, cin, sub, out_ready,
    input  in_ready, out_valid, r, carry, ovf
  );

  modport slave (
    input  in_valid, p, q, cin, sub, out_ready,
    output in_ready, out_valid, r, carry, ovf
  );
endinterface

// File: rtl/pipe_addsub.sv
// Pipelined ripple-carry adder/subtractor: one CHUNK-bit slice per stage,
// valid/ready handshake with a global stall that freezes every stage.
module pipe_addsub #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input logic          clk,
  input logic          rst_n,
  pipe_addsub_if.slave bus
);
  localparam int unsigned STAGES = WIDTH / CHUNK;
  localparam int unsigned CW     = CHUNK + 1;

  logic stall_c;
  logic ovf_q;

  assign stall_c      = bus.out_valid & ~bus.out_ready;
  assign bus.in_ready = ~stall_c;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int unsigned LO = k * CHUNK;
    localparam int unsigned HI = LO + CHUNK;

    // a_in_c/b_in_c hold the operand bits not yet consumed, slice k at the bottom
    logic [WIDTH-LO-1:0] a_in_c;
    logic [WIDTH-LO-1:0] b_in_c;
    logic                ci_c;
    logic                valid_in_c;
    logic [CW-1:0]       sum_c;
    logic [HI-1:0]       res_d;
    logic [HI-1:0]       res_q;
    logic                carry_q;
    logic                valid_q;

    if (k == 0) begin : g_head
      // q is inverted here so the slice adders never see sub
      assign a_in_c     = bus.p;
      assign b_in_c     = bus.sub ? ~bus.q : bus.q;
      assign ci_c       = bus.sub | bus.cin;
      assign valid_in_c = bus.in_valid;
      assign res_d      = sum_c[CHUNK-1:0];
    end else begin : g_body
      assign a_in_c     = g_st[k-1].g_fwd.a_q;
      assign b_in_c     = g_st[k-1].g_fwd.b_q;
      assign ci_c       = g_st[k-1].carry_q;
      assign valid_in_c = g_st[k-1].valid_q;
      assign res_d      = {sum_c[CHUNK-1:0], g_st[k-1].res_q};
    end

    assign sum_c = CW'(a_in_c[CHUNK-1:0]) + CW'(b_in_c[CHUNK-1:0]) + CW'(ci_c);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        res_q   <= '0;
      end else if (!stall_c) begin
        valid_q <= valid_in_c;
        carry_q <= sum_c[CHUNK];
        res_q   <= res_d;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [WIDTH-HI-1:0] a_q;
      logic [WIDTH-HI-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (!stall_c) begin
          a_q <= a_in_c[WIDTH-LO-1:CHUNK];
          b_q <= b_in_c[WIDTH-LO-1:CHUNK];
        end
      end
    end

    if (k == STAGES - 1) begin : g_tail
      // carry into the MSB recovered from the MSB sum bit and its operands
      logic cmsb_c;
      assign cmsb_c = sum_c[CHUNK-1] ^ a_in_c[CHUNK-1] ^ b_in_c[CHUNK-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (!stall_c) begin
          ovf_q <= sum_c[CHUNK] ^ cmsb_c;
        end
      end
    end
  end

  assign bus.out_valid = g_st[STAGES-1].valid_q;
  assign bus.r         = g_st[STAGES-1].res_q;
  assign bus.carry     = g_st[STAGES-1].carry_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_pipe_addsub.sv
// Self-checking bench for pipe_addsub: slot-level reference pipeline for the
// CHUNK=4 instance, plus latency/carry-chain vectors on CHUNK=1 and CHUNK=16.
module tb_pipe_addsub;
  localparam int unsigned W  = 16;
  localparam int unsigned MS = 4;

  typedef struct packed {
    logic          v;
    logic [W-1:0]  r;
    logic          c;
    logic          o;
  } slot_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   n_consumed;

  pipe_addsub_if #(.WIDTH(W)) m ();
  pipe_addsub_if #(.WIDTH(W)) sw1 ();
  pipe_addsub_if #(.WIDTH(W)) sw16 ();

  pipe_addsub #(.WIDTH(W), .CHUNK(4))  u_dut  (.clk(clk), .rst_n(rst_n), .bus(m));
  pipe_addsub #(.WIDTH(W), .CHUNK(1))  u_c1   (.clk(clk), .rst_n(rst_n), .bus(sw1));
  pipe_addsub #(.WIDTH(W), .CHUNK(16)) u_c16  (.clk(clk), .rst_n(rst_n), .bus(sw16));

  logic         s_valid;
  logic [W-1:0] s_p;
  logic [W-1:0] s_q;

  assign sw1.in_valid  = s_valid;
  assign sw1.p         = s_p;
  assign sw1.q         = s_q;
  assign sw1.cin       = 1'b0;
  assign sw1.sub       = 1'b0;
  assign sw1.out_ready = 1'b1;
  assign sw16.in_valid  = s_valid;
  assign sw16.p         = s_p;
  assign sw16.q         = s_q;
  assign sw16.cin       = 1'b0;
  assign sw16.sub       = 1'b0;
  assign sw16.out_ready = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic from integer sums: unsigned sum for r/carry, signed range for ovf
  function automatic slot_t ref_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic c, input logic s);
    slot_t        res;
    logic [W-1:0] bb;
    int           ci;
    int unsigned  usum;
    int           ssum;
    bb   = s ? ~b : b;
    ci   = s ? 1 : int'(c);
    usum = int'(a) + int'(bb) + ci;
    ssum = int'($signed(a)) + int'($signed(bb)) + ci;
    res.v = 1'b1;
    res.r = usum[W-1:0];
    res.c = usum[W];
    res.o = (ssum > 32767) || (ssum < -32768);
    return res;
  endfunction

  // Reference pipeline: MS slots that advance only when the output is not stalled
  slot_t slots [MS];
  slot_t nb;
  logic  exp_stall;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MS; i++) slots[i] = '0;
      check("rst out_valid", 32'(m.out_valid), 32'(0));
      check("rst r",         32'(m.r),         32'(0));
      check("rst in_ready",  32'(m.in_ready),  32'(1));
    end else begin
      exp_stall = slots[MS-1].v && !m.out_ready;
      check("in_ready", 32'(m.in_ready), 32'(!exp_stall));
      check("out_valid", 32'(m.out_valid), 32'(slots[MS-1].v));
      if (slots[MS-1].v) begin
        check("r",     32'(m.r),     32'(slots[MS-1].r));
        check("carry", 32'(m.carry), 32'(slots[MS-1].c));
        check("ovf",   32'(m.ovf),   32'(slots[MS-1].o));
        if (m.out_ready) n_consumed++;
      end
      if (!exp_stall) begin
        nb = m.in_valid ? ref_beat(m.p, m.q, m.cin, m.sub) : slot_t'('0);
        for (int i = MS - 1; i > 0; i--) slots[i] = slots[i-1];
        slots[0] = nb;
      end
    end
  end

  task automatic directed(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic s,
                          input logic [W-1:0] er, input logic ec, input logic eo);
    slot_t mdl;
    mdl = ref_beat(a, b, c, s);
    check({nm, " model r"},     32'(mdl.r), 32'(er));
    check({nm, " model carry"}, 32'(mdl.c), 32'(ec));
    check({nm, " model ovf"},   32'(mdl.o), 32'(eo));
    m.in_valid = 1'b1; m.p = a; m.q = b; m.cin = c; m.sub = s; m.out_ready = 1'b1;
    @(posedge clk); #1;
    m.in_valid = 1'b0;
    repeat (MS - 1) @(posedge clk);
    #1;
    check({nm, " out_valid"}, 32'(m.out_valid), 32'(1));
    check({nm, " r"},         32'(m.r),         32'(er));
    check({nm, " carry"},     32'(m.carry),     32'(ec));
    check({nm, " ovf"},       32'(m.ovf),       32'(eo));
    @(posedge clk); #1;
  endtask

  task automatic sweep(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] er, input logic ec);
    s_valid = 1'b1; s_p = a; s_q = b;
    @(posedge clk); #1;
    s_valid = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      check({nm, " c1 out_valid"},  32'(sw1.out_valid),  32'(cyc == 16));
      check({nm, " c16 out_valid"}, 32'(sw16.out_valid), 32'(cyc == 1));
      if (cyc == 16) begin
        check({nm, " c1 r"},     32'(sw1.r),     32'(er));
        check({nm, " c1 carry"}, 32'(sw1.carry), 32'(ec));
      end
      if (cyc == 1) begin
        check({nm, " c16 r"},     32'(sw16.r),     32'(er));
        check({nm, " c16 carry"}, 32'(sw16.carry), 32'(ec));
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int    sent;
    int    cyc;
    logic  acc;
    n_checks = 0; n_fail = 0; n_consumed = 0;
    rst_n = 1'b1;
    m.in_valid = 1'b0; m.p = '0; m.q = '0; m.cin = 1'b0; m.sub = 1'b0; m.out_ready = 1'b1;
    s_valid = 1'b0; s_p = '0; s_q = '0;
    #2 rst_n = 1'b0;
    #1;
    check("reset out_valid", 32'(m.out_valid), 32'(0));
    check("reset carry",     32'(m.carry),     32'(0));
    check("reset ovf",       32'(m.ovf),       32'(0));
    check("reset in_ready",  32'(m.in_ready),  32'(1));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    directed("add carry", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed("ovf",       16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed("ovf cin",   16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed("sub",       16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    directed("sub ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    directed("chain",     16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

    // 20 back-to-back random beats, consumer stalls in cycles 6..8
    n_consumed = 0;
    sent = 0;
    cyc  = 0;
    m.in_valid = 1'b1;
    m.p = 16'($urandom); m.q = 16'($urandom);
    m.cin = 1'($urandom); m.sub = 1'($urandom);
    while (cyc < 200 && n_consumed < 20) begin
      m.out_ready = !(cyc >= 6 && cyc <= 8);
      m.in_valid  = (sent < 20);
      @(negedge clk);
      acc = m.in_valid && m.in_ready;
      if (cyc >= 6 && cyc <= 8) check("stall in_ready", 32'(m.in_ready), 32'(0));
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        m.p = 16'($urandom); m.q = 16'($urandom);
        m.cin = 1'($urandom); m.sub = 1'($urandom);
      end
      cyc++;
    end
    check("stream accepted", 32'(sent), 32'(20));
    check("stream consumed", 32'(n_consumed), 32'(20));
    m.in_valid = 1'b0; m.out_ready = 1'b1;

    // Random valid/ready traffic
    repeat (300) begin
      m.in_valid  = 1'($urandom);
      m.out_ready = ($urandom_range(0, 3) != 0);
      m.p = 16'($urandom); m.q = 16'($urandom);
      m.cin = 1'($urandom); m.sub = 1'($urandom);
      @(posedge clk); #1;
    end
    m.in_valid = 1'b0; m.out_ready = 1'b1;
    repeat (MS + 2) @(posedge clk);
    #1;

    // Reset while three beats are in flight
    m.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m.p = 16'($urandom); m.q = 16'($urandom);
      m.cin = 1'($urandom); m.sub = 1'b0;
      @(posedge clk); #1;
    end
    m.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst out_valid", 32'(m.out_valid), 32'(0));
    check("midrst r",         32'(m.r),         32'(0));
    check("midrst carry",     32'(m.carry),     32'(0));
    check("midrst ovf",       32'(m.ovf),       32'(0));
    check("midrst in_ready",  32'(m.in_ready),  32'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    directed("post rst", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    #1;

    sweep("sw ffff", 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
    sweep("sw 0f0f", 16'h0F0F, 16'h00F1, 16'h1000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_addsub.md
# pipe_addsub

Parametrised, pipelined ripple-carry adder/subtractor for the datapath. Each stage adds one CHUNK-bit slice of WIDTH-bit operands and registers the slice carry for the next stage. Results come out in order at one per clock. A valid/ready handshake lets the block sit between buffered producers and consumers that may apply backpressure.

## Interface
- WIDTH, 16: operand and result width; must be an integer multiple of CHUNK.
- CHUNK, 4: bits added per pipeline stage, CHUNK ≥ 1; STAGES = WIDTH/CHUNK.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block can accept a beat this cycle.
- p  in  WIDTH  operand A.
- q  in  WIDTH  operand B.
- cin  in  1  carry-in; used only when sub=0.
- sub  in  1  0: add, 1: subtract (p − q).
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result this cycle.
- r  out  WIDTH  sum/difference.
- carry  out  1  carry out of the MSB. In subtract mode, 1 means no borrow.
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- Add: r = p + q + cin. Subtract: r = p + ~q + 1, and cin is ignored. Arithmetic is modulo 2^WIDTH; carry holds bit WIDTH of the full sum.
- Stage k (0..STAGES−1) adds slice [k·CHUNK +: CHUNK] using the registered carry from stage k−1. Stage 0 uses cin, or 1 when sub=1.
- ~q is formed at the input register, so the slice adders never see sub.
- Upper operand slices travel through delay registers until their stage. Completed lower result slices travel through delay registers until the last stage, so all of r emerges aligned.
- The last stage also produces the MSB carry-in, which is used to form ovf.
- Each stage carries a valid bit. Bubbles propagate as invalid and never produce out_valid.
- Stall: stall = out_valid & ~out_ready. When stall=1, every pipeline register holds, including data, carries and valid bits.
- in_ready = ~stall, which is combinational from out_valid and out_ready.
- A beat is accepted when in_valid & in_ready. A beat is consumed when out_valid & out_ready.
- Simultaneous accept and consume in the same cycle is legal and sustains one beat per clock.
- When in_valid=0 and in_ready=1, a bubble enters the pipeline. The values on p, q, cin and sub are then don't-care.
- r, carry and ovf are registered outputs. They must hold stable while out_valid=1 and out_ready=0.

## Timing
- Latency: a beat accepted at edge n appears with out_valid=1 after edge n+STAGES−1. For defaults, that is 4 cycles from acceptance to the output register.
- Throughput: 1 beat/clock with out_ready held high.
- Reset (rst_n=0, asynchronous): all valid bits clear immediately. out_valid=0, r=0, carry=0, ovf=0, in_ready=1.
- Reset during operation discards every in-flight beat; no partial result is ever presented.
- First acceptance is possible on the first rising edge after rst_n deasserts.
- Stall boundary: if out_ready drops while the pipeline is full, nothing is lost or duplicated. Beats resume in order when out_ready rises.
- Degenerate CHUNK=WIDTH: STAGES=1, a single registered stage.

## Test plan
- Add carry-out (WIDTH=16, CHUNK=4): p=0xFFFF, q=0x0001, cin=0, sub=0 -> 4 cycles later r=0x0000, carry=1, ovf=0.
- Signed overflow: p=0x7FFF, q=0x0001, cin=0, sub=0 -> r=0x8000, carry=0, ovf=1. Repeat with cin=1 and q=0x0000 -> same result.
- Subtract: p=0x0005, q=0x0007, sub=1, cin=1 -> r=0xFFFE, carry=0, ovf=0. Then p=0x8000, q=0x0001, sub=1 -> r=0x7FFF, carry=1, ovf=1.
- Streaming with backpressure: 20 back-to-back random beats with out_ready low for cycles 6–8.
  - in_ready must read 0 while stalled.
  - All 20 results must arrive in order, matching the reference model, with none dropped or duplicated.
- Reset mid-flight: accept 3 beats, then assert rst_n low for 1 cycle while they are in flight.
  - out_valid=0, r=0, carry=0 and ovf=0 must hold immediately.
  - No stale result may appear afterwards.
  - A new beat accepted after reset must return correctly after 4 cycles.
- Parameter sweep: CHUNK ∈ {1, 4, 16}, WIDTH=16, with exhaustive carry-chain vectors (0xFFFF+0x0001, 0x0F0F+0x00F1) -> correct r and carry, with latency STAGES.
